// File: rtl/prio_arb_ctrl.sv
// Registered arbiter that shares one resource among 2**N requesters,
// with grant holding, release handshake, hold watchdog and round-robin.
module prio_arb_ctrl #(
  parameter int N       = 2,
  parameter int MAXHOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2**N-1:0] req,
  input  logic            done,
  input  logic            rr_mode,
  output logic [2**N-1:0] gnt,
  output logic [N-1:0]    gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam int R = 2**N;
  localparam logic [7:0] CAP = 8'(MAXHOLD - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t       state, state_n;
  logic [R-1:0] gnt_n;
  logic [N-1:0] id_n;
  logic         valid_n;
  logic         to_n;
  logic [N-1:0] ptr, ptr_n;
  logic [7:0]   cnt, cnt_n;
  logic         mode_q, mode_n;

  logic [R-1:0] elig;
  logic         use_mode;
  logic         found;
  logic [N-1:0] win;
  logic         drop;
  logic         cap;
  logic         rel;

  // Fixed mode scans down from the top index; round-robin from ptr.
  function automatic logic [N:0] pick(
    input logic [R-1:0] v,
    input logic         m,
    input logic [N-1:0] p
  );
    logic [N-1:0] idx;
    logic [N-1:0] w;
    logic         f;
    f = 1'b0;
    w = '0;
    for (int j = 0; j < R; j++) begin
      idx = m ? N'(p - N'(j)) : N'(R - 1 - j);
      if (!f && v[idx]) begin
        f = 1'b1;
        w = idx;
      end
    end
    return {f, w};
  endfunction

  assign drop = ~req[gnt_id];
  assign cap  = (cnt == CAP);
  assign rel  = drop | done | cap;

  always_comb begin
    elig     = req;
    use_mode = rr_mode;
    if (state == BUSY) begin
      elig     = req & ~gnt;
      use_mode = mode_q;
    end
    {found, win} = pick(elig, use_mode, ptr);
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    id_n    = gnt_id;
    valid_n = gnt_valid;
    to_n    = 1'b0;
    ptr_n   = ptr;
    cnt_n   = cnt;
    mode_n  = mode_q;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = BUSY;
          gnt_n   = R'(1) << win;
          id_n    = win;
          valid_n = 1'b1;
          cnt_n   = '0;
          ptr_n   = win - N'(1);
          mode_n  = rr_mode;
        end
      end
      BUSY: begin
        if (rel) begin
          to_n = cap & ~drop & ~done;
          if (found) begin
            gnt_n   = R'(1) << win;
            id_n    = win;
            valid_n = 1'b1;
            cnt_n   = '0;
            ptr_n   = win - N'(1);
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            id_n    = '0;
            valid_n = 1'b0;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= N'(R - 1);
      cnt       <= '0;
      mode_q    <= 1'b0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_id    <= id_n;
      gnt_valid <= valid_n;
      timeout   <= to_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      mode_q    <= mode_n;
    end
  end

endmodule

// File: tb/tb_prio_arb_ctrl.sv
// Directed and randomized checks of prio_arb_ctrl against
// a behavioural grant model.
module tb_prio_arb_ctrl;

  localparam int N  = 2;
  localparam int R  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [R-1:0] req = '0;
  logic         done = 1'b0;
  logic         rr_mode = 1'b0;
  logic [R-1:0] gnt;
  logic [N-1:0] gnt_id;
  logic         gnt_valid;
  logic         timeout;

  int checks = 0;
  int failures = 0;

  int m_busy, m_id, m_ptr, m_cnt, m_mode, m_to;
  int seen [R];

  prio_arb_ctrl #(.N(N), .MAXHOLD(MH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .done(done),
    .rr_mode(rr_mode),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .gnt_valid(gnt_valid),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int vec, input int mode, input int ptr);
    if (mode == 0) begin
      for (int i = R - 1; i >= 0; i--)
        if ((vec >> i) & 1) return i;
    end else begin
      for (int j = 0; j < R; j++) begin
        int k;
        k = (ptr - j + R) % R;
        if ((vec >> k) & 1) return k;
      end
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_busy = 0; m_id = 0; m_ptr = R - 1;
    m_cnt = 0; m_mode = 0; m_to = 0;
  endtask

  task automatic m_grant(input int w);
    m_busy = 1; m_id = w; m_cnt = 0;
    m_ptr = (w - 1 + R) % R;
  endtask

  task automatic m_step(input int r, input int d, input int m);
    int w;
    bit drp, frc;
    m_to = 0;
    if (!m_busy) begin
      if (r != 0) begin
        m_mode = m;
        m_grant(pick(r, m_mode, m_ptr));
      end
    end else begin
      drp = ((r >> m_id) & 1) == 0;
      frc = (m_cnt == MH - 1);
      if (drp || d != 0 || frc) begin
        m_to = (frc && !drp && d == 0) ? 1 : 0;
        w = pick(r & ~(1 << m_id), m_mode, m_ptr);
        if (w >= 0) m_grant(w);
        else begin m_busy = 0; m_id = 0; end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic m_check(input string tag);
    chk({tag, ".gnt"}, int'(gnt), m_busy ? (1 << m_id) : 0);
    chk({tag, ".id"}, int'(gnt_id), m_busy ? m_id : 0);
    chk({tag, ".valid"}, int'(gnt_valid), m_busy);
    chk({tag, ".to"}, int'(timeout), m_to);
  endtask

  task automatic cyc(input logic [R-1:0] r, input logic d, input logic m);
    req = r; done = d; rr_mode = m;
    @(posedge clk);
    m_step(int'(r), int'(d), int'(m));
    #1;
    m_check("model");
  endtask

  initial begin
    m_reset();
    #2;
    chk("rst.gnt", int'(gnt), 0);
    chk("rst.id", int'(gnt_id), 0);
    chk("rst.valid", int'(gnt_valid), 0);
    chk("rst.to", int'(timeout), 0);
    #10 rst_n = 1'b1;

    // fixed winner
    cyc(4'b0110, 1'b0, 1'b0);
    chk("fix.gnt", int'(gnt), 4);
    chk("fix.id", int'(gnt_id), 2);
    chk("fix.valid", int'(gnt_valid), 1);

    // handoff on done, then drop to idle
    cyc(4'b0110, 1'b1, 1'b0);
    chk("hand.gnt", int'(gnt), 2);
    chk("hand.id", int'(gnt_id), 1);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("hand.idle", int'(gnt), 0);
    chk("hand.vld", int'(gnt_valid), 0);

    // watchdog, single requester
    for (int k = 0; k < MH; k++) begin
      cyc(4'b1000, 1'b0, 1'b0);
      chk("wd.hold", int'(gnt_id), 3);
      chk("wd.noto", int'(timeout), 0);
    end
    cyc(4'b1000, 1'b0, 1'b0);
    chk("wd.rel", int'(gnt), 0);
    chk("wd.to", int'(timeout), 1);
    cyc(4'b1000, 1'b0, 1'b0);
    chk("wd.retake", int'(gnt), 8);
    chk("wd.to_clr", int'(timeout), 0);
    cyc(4'b0000, 1'b0, 1'b0);

    // watchdog with contention
    for (int k = 0; k < MH; k++) cyc(4'b1001, 1'b0, 1'b0);
    chk("wdc.pre", int'(gnt_id), 3);
    cyc(4'b1001, 1'b0, 1'b0);
    chk("wdc.id", int'(gnt_id), 0);
    chk("wdc.gnt", int'(gnt), 1);
    chk("wdc.to", int'(timeout), 1);
    cyc(4'b0000, 1'b0, 1'b0);

    // async reset mid-grant
    cyc(4'b0100, 1'b0, 1'b0);
    chk("ar.hold", int'(gnt_id), 2);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("ar.gnt", int'(gnt), 0);
    chk("ar.id", int'(gnt_id), 0);
    chk("ar.valid", int'(gnt_valid), 0);
    chk("ar.to", int'(timeout), 0);
    #1 rst_n = 1'b1;

    // round-robin rotation, also proves ptr reset to 3
    foreach (seen[i]) seen[i] = 0;
    cyc(4'b1111, 1'b0, 1'b1);
    chk("rr.0", int'(gnt_id), 3);
    for (int k = 1; k < 9; k++) begin
      cyc(4'b1111, 1'b1, 1'b1);
      chk($sformatf("rr.%0d", k), int'(gnt_id), (3 - k + 8) % 4);
      seen[gnt_id]++;
    end
    foreach (seen[i]) chk($sformatf("rr.fair%0d", i), seen[i], 2);
    cyc(4'b0000, 1'b0, 1'b0);

    // randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      logic [R-1:0] r;
      r = R'($urandom);
      if ($urandom_range(0, 9) == 0) r = '0;
      cyc(r, ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
